// File: rtl/clkdiv_param.sv
// rtl/clkdiv_param.sv - parameterised clock divider with phase slip and optional half ratio
//
// Purpose: divides CLKI by DIV_INT (or DIV_INT+0.5 when the half-ratio build
// option is enabled) and produces a registered divided clock, a strobe on the
// first cycle of each high phase, a ready flag and the current phase count.
//
// Build option: CLKDIV_PARAM_HALF_EN
//   defined   -> DIV_HALF=1 alternates periods DIV_INT, DIV_INT+1, ...
//   undefined -> alternation logic absent, DIV_HALF ignored (integer only)
//
// Ports:
//   CLKI      in   single clock, all state updates on its rising edge
//   RST       in   synchronous active-high reset
//   ALIGNWD   in   phase-slip request; each rising edge (as sampled) delays
//                  every following divided-clock edge by one CLKI cycle
//   CDIVX     out  registered divided clock, high for floor(P/2) cycles
//   CDIVX_STB out  one-cycle pulse on the first cycle of each CDIVX high phase
//   RDY       out  high once the divider is running
//   PHASE     out  current count within the divided period (0..P-1)

module clkdiv_param #(
  parameter int unsigned DIV_INT  = 2,
  parameter int unsigned DIV_HALF = 0
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       ALIGNWD,
  output logic       CDIVX,
  output logic       CDIVX_STB,
  output logic       RDY,
  output logic [4:0] PHASE
);

  localparam logic [4:0] PerBase = 5'(DIV_INT);

`ifdef CLKDIV_PARAM_HALF_EN
  localparam logic HalfMode = (DIV_HALF != 0);
`else
  localparam logic HalfMode = 1'b0 && (DIV_HALF != 0);
`endif

  // Start-up: arm_q sets on the first edge with RST low, rdy_q on the second.
  logic       arm_q;
  logic       rdy_q;
  logic       rdy_d;

  // ALIGNWD is registered once; alw_prev_q is the sample before that, so a
  // slip is a registered rising edge and never a combinational input path.
  logic       alw_q;
  logic       alw_prev_q;

  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic       cdivx_q;
  logic       cdivx_d;
  logic       stb_q;
  logic       stb_d;

  logic       slip;
  logic       hold;
  logic       last;
  logic [4:0] per_cur;
  logic [4:0] per_nxt;

  // Alternation state: 0 = short period (DIV_INT), 1 = long (DIV_INT+1).
  logic       long_q;
  logic       long_d;

  assign slip    = alw_q & ~alw_prev_q;
  // Slips seen before the divider is running are simply dropped.
  assign hold    = rdy_q & slip;
  assign per_cur = PerBase + {4'b0000, HalfMode & long_q};
  assign last    = (cnt_q == (per_cur - 5'd1));
  assign rdy_d   = rdy_q | arm_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!rdy_q) begin
      cnt_d = 5'd0;
    end else if (!hold) begin
      cnt_d = last ? 5'd0 : (cnt_q + 5'd1);
    end
  end

  // Outputs are computed from the next count so they land in the same
  // register stage as PHASE. In a held cycle cnt and period are unchanged,
  // so CDIVX naturally repeats; only the strobe has to be suppressed.
  assign per_nxt = PerBase + {4'b0000, HalfMode & long_d};
  assign cdivx_d = rdy_d & (cnt_d < (per_nxt >> 1));
  assign stb_d   = rdy_d & ~hold & (cnt_d == 5'd0);

`ifdef CLKDIV_PARAM_HALF_EN
  always_comb begin
    long_d = long_q;
    if (!rdy_q) begin
      long_d = 1'b0;
    end else if (!hold && last) begin
      long_d = HalfMode & ~long_q;
    end
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      long_q <= 1'b0;
    end else begin
      long_q <= long_d;
    end
  end
`else
  assign long_q = 1'b0;
  assign long_d = 1'b0;
`endif

  always_ff @(posedge CLKI) begin
    if (RST) begin
      arm_q      <= 1'b0;
      rdy_q      <= 1'b0;
      alw_q      <= 1'b0;
      alw_prev_q <= 1'b0;
      cnt_q      <= 5'd0;
      cdivx_q    <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      arm_q      <= 1'b1;
      rdy_q      <= rdy_d;
      alw_q      <= ALIGNWD;
      alw_prev_q <= alw_q;
      cnt_q      <= cnt_d;
      cdivx_q    <= cdivx_d;
      stb_q      <= stb_d;
    end
  end

  assign CDIVX     = cdivx_q;
  assign CDIVX_STB = stb_q;
  assign RDY       = rdy_q;
  assign PHASE     = cnt_q;

endmodule

// File: tb/tb_clkdiv_param.sv
// tb/tb_clkdiv_param.sv - scoreboard bench for clkdiv_param across several ratios

module tb_clkdiv_param;

  localparam int NI = 7;
  localparam int DIVS  [NI] = '{2, 5, 4, 6, 16, 3, 16};
  localparam int HALFS [NI] = '{0, 0, 0, 0, 0, 1, 1};

  logic clk;
  logic rst;
  logic alw;

  logic [7:0] dut_out [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic       cdivx;
    logic       stb;
    logic       rdy;
    logic [4:0] phase;

    clkdiv_param #(
      .DIV_INT (DIVS[g]),
      .DIV_HALF(HALFS[g])
    ) u_dut (
      .CLKI     (clk),
      .RST      (rst),
      .ALIGNWD  (alw),
      .CDIVX    (cdivx),
      .CDIVX_STB(stb),
      .RDY      (rdy),
      .PHASE    (phase)
    );

    assign dut_out[g] = {rdy, cdivx, stb, phase};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {RDY, CDIVX, CDIVX_STB, PHASE[4:0]} per instance, one per edge.
  logic [7:0] exp_q [NI][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state, per instance.
  int m_since [NI];
  bit m_rdy   [NI];
  int m_cnt   [NI];
  bit m_long  [NI];
  bit m_s1    [NI];
  bit m_s2    [NI];

  function automatic bit half_eff(input int i);
`ifdef CLKDIV_PARAM_HALF_EN
    return HALFS[i] != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int per_len(input int i);
    return DIVS[i] + ((half_eff(i) && m_long[i]) ? 1 : 0);
  endfunction

  // Drive one cycle of inputs and predict what every instance shows after
  // the coming rising edge.
  task automatic step(input logic r, input logic a);
    @(negedge clk);
    rst = r;
    alw = a;
    for (int i = 0; i < NI; i++) begin
      bit         hold;
      bit         nr;
      int         p;
      logic [7:0] e;
      if (r) begin
        m_since[i] = 0;
        m_rdy[i]   = 1'b0;
        m_cnt[i]   = 0;
        m_long[i]  = 1'b0;
        m_s1[i]    = 1'b0;
        m_s2[i]    = 1'b0;
        e          = 8'h00;
      end else begin
        // Slip: ALIGNWD seen high at the previous edge but low the edge before.
        hold = m_rdy[i] && m_s1[i] && !m_s2[i];
        nr   = m_rdy[i] || (m_since[i] >= 1);
        if (m_since[i] < 2) m_since[i]++;
        if (!m_rdy[i]) begin
          m_cnt[i]  = 0;
          m_long[i] = 1'b0;
        end else if (!hold) begin
          m_cnt[i]++;
          if (m_cnt[i] >= per_len(i)) begin
            m_cnt[i] = 0;
            if (half_eff(i)) m_long[i] = !m_long[i];
          end
        end
        m_rdy[i] = nr;
        p = per_len(i);
        e = {nr, nr && (m_cnt[i] < p / 2), nr && !hold && (m_cnt[i] == 0), 5'(m_cnt[i])};
        m_s2[i] = m_s1[i];
        m_s1[i] = a;
      end
      exp_q[i].push_back(e);
    end
  endtask

  // Monitor: compares each instance's outputs after every rising edge.
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        total++;
        if (dut_out[i] !== e) begin
          bad++;
          $display("FAIL out inst%0d div=%0d cyc=%0d got rdy/cdivx/stb/phase=%b/%b/%b/%0d want %b/%b/%b/%0d",
                   i, DIVS[i], cyc, dut_out[i][7], dut_out[i][6], dut_out[i][5], dut_out[i][4:0],
                   e[7], e[6], e[5], e[4:0]);
        end
      end
    end
  end

  initial begin
    bit a_hold;
    rst = 1'b1;
    alw = 1'b0;

    // Reset then free run.
    repeat (3) step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);

    // Single-cycle slip pulses at each phase of the DIV_INT=4 instance.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 40 && m_cnt[2] != ph; k++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0);
    end

    // Slips in consecutive periods.
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
    end

    // ALIGNWD held high: only one slip.
    repeat (20) step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // ALIGNWD high through reset release: slip must be discarded.
    repeat (2) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Mid-period reset on the DIV_INT=6 instance at PHASE 2.
    for (int k = 0; k < 40 && m_cnt[3] != 2; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // Randomised traffic.
    a_hold = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) a_hold = ~a_hold;
      step(($urandom_range(0, 299) == 0), a_hold);
    end
    repeat (10) step(1'b0, 1'b0);

    @(posedge clk);
    #3;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL drain inst%0d left=%0d want 0", i, exp_q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
